kbd_key_decoder: RTL and testbench
==================================

# kbd_key_decoder

Converts the byte stream from the PS/2 receiver into held-level key signals for the character controller. Tracks make, break (F0) and extended (E0) prefixes, and drives registered `key_space`, `key_left` and `key_right` levels that stay high while a key is physically held. It sits directly upstream of the movement/jump controller and directly downstream of the PS/2 byte receiver.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `PREFIX_TIMEOUT_US`, 2000: maximum wait after an E0/F0 prefix before the sequence is abandoned.
- Derived: `TIMEOUT_CYCLES = CLK_FREQ/1_000_000 * PREFIX_TIMEOUT_US`. The counter width is `$clog2(TIMEOUT_CYCLES)+1`.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `scan_code`  in  8: received byte. Valid only when `scan_valid` is high.
- `scan_valid`  in  1: one-cycle strobe per received byte.
- `rx_error`  in  1: one-cycle strobe for a parity or framing error from the receiver.
- `key_space`  out  1: space held (make 29).
- `key_left`  out  1: left arrow held (E0 6B).
- `key_right`  out  1: right arrow held (E0 74).
- `seq_error`  out  1: one-cycle pulse on prefix timeout, on `rx_error`, or on keyboard error code 00/FF.

## Operation
- FSM states:
  - `IDLE`
  - `EXT`: E0 seen.
  - `BRK`: F0 seen.
  - `EXT_BRK`: E0 F0 seen.
- Transitions on `scan_valid`:
  - `IDLE`: E0 goes to `EXT`. F0 goes to `BRK`. 29 sets `key_space`. Any other byte is ignored and the state stays `IDLE`.
  - `EXT`: F0 goes to `EXT_BRK`. 6B sets `key_left`. 74 sets `key_right`. Any other byte is ignored. All cases except F0 return to `IDLE`.
  - `BRK`: 29 clears `key_space`. Any byte returns to `IDLE`.
  - `EXT_BRK`: 6B clears `key_left`. 74 clears `key_right`. Any byte returns to `IDLE`.
- Non-extended 6B/74 (keypad 4/6) do not affect the arrow outputs. Extended 29 does not affect `key_space`.
- Special bytes handled in any state:
  - 00 or FF: clear all three keys, pulse `seq_error`, go to `IDLE`.
  - AA (self-test pass) and FA (ack): no key change, go to `IDLE`.
- Typematic repeats (the same make code arriving again): the key stays set, with no glitch.
- Keys are independent. Left and right may both be high; arbitrating between them is the controller's job.
- Timeout:
  - A counter runs in every non-`IDLE` state and is cleared on entry to any state and on every `scan_valid`.
  - When it reaches `TIMEOUT_CYCLES-1`: go to `IDLE`, pulse `seq_error`, leave key levels unchanged.
- `rx_error`: the byte is discarded, the state goes to `IDLE`, and `seq_error` pulses. Key levels are unchanged.
  - If `rx_error` and `scan_valid` are high in the same cycle, `rx_error` wins and the byte is ignored.

## Timing
- Reset (`rst_n` low, asynchronous): `state=IDLE`, counter=0, `key_space=0`, `key_left=0`, `key_right=0`, `seq_error=0`.
  - Outputs go low immediately, without waiting for a clock edge.
  - Reset in the middle of a prefix discards the sequence. After release, the next byte is decoded from `IDLE`.
- Latency: a byte strobed at edge N updates the key output and state at edge N+1. Outputs are registered, with no combinational path from input to output.
- `seq_error` is high for exactly one cycle, in the cycle after the causing event.
- A timeout fires exactly `TIMEOUT_CYCLES` cycles after the last prefix byte if no further `scan_valid` arrives.
- `scan_valid` may arrive on consecutive cycles. Every strobe is consumed, and no back-pressure exists.
- Typical PS/2 byte spacing is about 1 ms at 100 MHz, so a 2 ms timeout does not fire during normal E0 F0 xx sequences.

## Test plan
- Reset, then 29 → `key_space=1` one cycle later. Then F0, 29 → `key_space=0`. `key_left` and `key_right` stay 0 throughout, and `seq_error` never pulses.
- E0 6B, then E0 74 → `key_left=1` and `key_right=1` together. Then E0 F0 6B → `key_left=0` while `key_right` stays 1.
- 6B without prefix (keypad 4) → all outputs stay 0. Then E0 29 → `key_space` stays 0.
- E0 followed by no byte for `TIMEOUT_CYCLES` → `seq_error` pulses for 1 cycle and state is `IDLE`. A following 6B leaves `key_left=0`.
- `key_space` held: 29 sent ×5 (typematic) → output stays 1 continuously. Then FF → all keys 0 and `seq_error` pulses. Also assert `rx_error` together with `scan_valid`=29 → the byte is ignored.
- Assert `rst_n` low asynchronously mid-clock while in `EXT_BRK` with `key_right=1` → output drops without a clock edge. After release, 74 alone → no change.

Source files
------------

// File: rtl/kbd_key_decoder_if.sv
// Byte-stream input and held-key outputs between the PS/2 receiver, the key decoder and the controller.
interface kbd_key_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       rx_error;
  logic       key_space;
  logic       key_left;
  logic       key_right;
  logic       seq_error;

  modport master (
    output scan_code, scan_valid, rx_error,
    input  key_space, key_left, key_right, seq_error
  );

  modport slave (
    input  scan_code, scan_valid, rx_error,
    output key_space, key_left, key_right, seq_error
  );
endinterface

// File: rtl/kbd_key_decoder.sv
// Decodes PS/2 set-2 make/break/extended sequences into held levels for space, left and right.
module kbd_key_decoder #(
  parameter int CLK_FREQ          = 100_000_000,
  parameter int PREFIX_TIMEOUT_US = 2000
) (
  input  logic           clk,
  input  logic           rst_n,
  kbd_key_decoder_if.slave bus
);
  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * PREFIX_TIMEOUT_US;
  localparam int CW             = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt;
  logic            r_space, r_left, r_right, r_seq_err;
  logic            w_space, w_left, w_right, w_seq_err;
  logic            w_timeout, w_cnt_clr;

  always_comb begin
    w_state_next = r_state;
    w_space      = r_space;
    w_left       = r_left;
    w_right      = r_right;
    w_seq_err    = 1'b0;
    w_timeout    = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // rx_error beats a simultaneous byte; a byte beats a coincident timeout
    if (bus.rx_error) begin
      w_state_next = IDLE;
      w_seq_err    = 1'b1;
    end else if (bus.scan_valid) begin
      if (bus.scan_code == 8'h00 || bus.scan_code == 8'hFF) begin
        w_state_next = IDLE;
        w_space      = 1'b0;
        w_left       = 1'b0;
        w_right      = 1'b0;
        w_seq_err    = 1'b1;
      end else if (bus.scan_code == 8'hAA || bus.scan_code == 8'hFA) begin
        w_state_next = IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.scan_code == 8'hE0)      w_state_next = EXT;
            else if (bus.scan_code == 8'hF0) w_state_next = BRK;
            else if (bus.scan_code == 8'h29) w_space = 1'b1;
          end
          EXT: begin
            w_state_next = IDLE;
            if (bus.scan_code == 8'hF0)      w_state_next = EXT_BRK;
            else if (bus.scan_code == 8'h6B) w_left  = 1'b1;
            else if (bus.scan_code == 8'h74) w_right = 1'b1;
          end
          BRK: begin
            w_state_next = IDLE;
            if (bus.scan_code == 8'h29) w_space = 1'b0;
          end
          EXT_BRK: begin
            w_state_next = IDLE;
            if (bus.scan_code == 8'h6B)      w_left  = 1'b0;
            else if (bus.scan_code == 8'h74) w_right = 1'b0;
          end
          default: w_state_next = IDLE;
        endcase
      end
    end else if (w_timeout) begin
      w_state_next = IDLE;
      w_seq_err    = 1'b1;
    end

    w_cnt_clr = bus.scan_valid || bus.rx_error || (r_state == IDLE) || (w_state_next != r_state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_space   <= 1'b0;
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      r_space   <= w_space;
      r_left    <= w_left;
      r_right   <= w_right;
      r_seq_err <= w_seq_err;
    end
  end

  assign bus.key_space = r_space;
  assign bus.key_left  = r_left;
  assign bus.key_right = r_right;
  assign bus.seq_error = r_seq_err;
endmodule

// File: tb/tb_kbd_key_decoder.sv
// Directed bench for kbd_key_decoder: vector table plus timeout and async-reset sequences.
module tb_kbd_key_decoder;
  localparam int TCYC = 20;  // 1 MHz clock, 20 us prefix timeout

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;

  kbd_key_decoder_if bus ();

  kbd_key_decoder #(.CLK_FREQ(1_000_000), .PREFIX_TIMEOUT_US(20)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       v;
    logic       rx;
    logic [3:0] exp;  // {space, left, right, seq_error}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] outs();
    return {bus.key_space, bus.key_left, bus.key_right, bus.seq_error};
  endfunction

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {spc,lft,rgt,err}=%b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Drive one cycle of input at a negedge, return outputs sampled at the next negedge
  task automatic cyc(input logic [7:0] c, input logic v, input logic rx, output logic [3:0] o);
    bus.scan_code  = c;
    bus.scan_valid = v;
    bus.rx_error   = rx;
    @(negedge clk);
    o = outs();
  endtask

  task automatic idle_inputs();
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    bus.rx_error   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] o;
    int first, highs, errs;

    idle_inputs();
    #1;
    chk("reset_state", outs(), 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{8'h29, 1, 0, 4'b1000});
    vecs.push_back('{8'hF0, 1, 0, 4'b1000});
    vecs.push_back('{8'h29, 1, 0, 4'b0000});
    vecs.push_back('{8'hE0, 1, 0, 4'b0000});
    vecs.push_back('{8'h6B, 1, 0, 4'b0100});
    vecs.push_back('{8'hE0, 1, 0, 4'b0100});
    vecs.push_back('{8'h74, 1, 0, 4'b0110});
    vecs.push_back('{8'hE0, 1, 0, 4'b0110});
    vecs.push_back('{8'hF0, 1, 0, 4'b0110});
    vecs.push_back('{8'h6B, 1, 0, 4'b0010});
    vecs.push_back('{8'hE0, 1, 0, 4'b0010});
    vecs.push_back('{8'hF0, 1, 0, 4'b0010});
    vecs.push_back('{8'h74, 1, 0, 4'b0000});
    vecs.push_back('{8'h6B, 1, 0, 4'b0000});
    vecs.push_back('{8'hE0, 1, 0, 4'b0000});
    vecs.push_back('{8'h29, 1, 0, 4'b0000});
    for (int i = 0; i < 5; i++) vecs.push_back('{8'h29, 1, 0, 4'b1000});
    vecs.push_back('{8'hE0, 1, 0, 4'b1000});
    vecs.push_back('{8'hF0, 1, 0, 4'b1000});
    vecs.push_back('{8'h29, 1, 0, 4'b1000});
    vecs.push_back('{8'hFF, 1, 0, 4'b0001});
    vecs.push_back('{8'h00, 0, 0, 4'b0000});
    vecs.push_back('{8'h29, 1, 1, 4'b0001});
    vecs.push_back('{8'h00, 0, 0, 4'b0000});
    vecs.push_back('{8'hF0, 1, 0, 4'b0000});
    vecs.push_back('{8'h00, 0, 1, 4'b0001});
    vecs.push_back('{8'h29, 1, 0, 4'b1000});
    vecs.push_back('{8'hE0, 1, 0, 4'b1000});
    vecs.push_back('{8'hAA, 1, 0, 4'b1000});
    vecs.push_back('{8'h6B, 1, 0, 4'b1000});
    vecs.push_back('{8'hE0, 1, 0, 4'b1000});
    vecs.push_back('{8'h6B, 1, 0, 4'b1100});
    vecs.push_back('{8'hF0, 1, 0, 4'b1100});
    vecs.push_back('{8'hFA, 1, 0, 4'b1100});
    vecs.push_back('{8'h6B, 1, 0, 4'b1100});
    vecs.push_back('{8'hF0, 1, 0, 4'b1100});
    vecs.push_back('{8'h6B, 1, 0, 4'b1100});
    vecs.push_back('{8'h00, 1, 0, 4'b0001});
    vecs.push_back('{8'h00, 0, 0, 4'b0000});

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].code, vecs[i].v, vecs[i].rx, o);
      chk($sformatf("vec%0d_code%02h", i, vecs[i].code), o, vecs[i].exp);
    end

    // Prefix timeout: pulse exactly TCYC cycles after the E0 edge, one cycle wide
    cyc(8'hE0, 1, 0, o);
    chk("to_prefix", o, 4'b0000);
    first = -1;
    highs = 0;
    for (int k = 1; k <= TCYC + 3; k++) begin
      cyc(8'h00, 0, 0, o);
      if (o[0]) begin
        highs++;
        if (first < 0) first = k;
      end
    end
    chk_int("to_pulse_cycle", first, TCYC);
    chk_int("to_pulse_width", highs, 1);
    cyc(8'h6B, 1, 0, o);
    chk("to_then_6B", o, 4'b0000);

    // Slow but in-time sequence: no timeout, extended make still decodes
    cyc(8'hE0, 1, 0, o);
    errs = 0;
    for (int k = 0; k < TCYC - 3; k++) begin
      cyc(8'h00, 0, 0, o);
      if (o[0]) errs++;
    end
    chk_int("slow_no_timeout", errs, 0);
    cyc(8'h74, 1, 0, o);
    chk("slow_E0_74", o, 4'b0010);

    // Async reset while in EXT_BRK with key_right held
    cyc(8'hE0, 1, 0, o);
    cyc(8'hF0, 1, 0, o);
    chk("pre_reset", o, 4'b0010);
    idle_inputs();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8'h74, 1, 0, o);
    chk("post_reset_74", o, 4'b0000);
    cyc(8'hE0, 1, 0, o);
    cyc(8'h74, 1, 0, o);
    chk("post_reset_E0_74", o, 4'b0010);
    cyc(8'h00, 0, 0, o);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
